// File: rtl/gpio_debounce.sv
// Per-pin two-flop synchronizer followed by a stable-count debounce filter,
// producing debounced levels plus registered rise/fall/any-edge pulses.
module gpio_debounce #(
  parameter int unsigned AW = 32,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [AW-1:0] pad_in,
  input  logic [CW-1:0] cfg_period,
  input  logic [AW-1:0] cfg_bypass,
  output logic [AW-1:0] gpio_in,
  output logic [AW-1:0] rise,
  output logic [AW-1:0] fall,
  output logic          edge_any
);

  logic [AW-1:0] sync1;
  logic [AW-1:0] sync2;
  logic [AW-1:0] state;
  logic [AW-1:0] state_next;
  logic [AW-1:0] rise_next;
  logic [AW-1:0] fall_next;
  logic [CW-1:0] cnt      [AW];
  logic [CW-1:0] cnt_next [AW];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pad_in;
      sync2 <= sync1;
    end
  end

  // The >= compare lets a period lowered mid-count commit on the next edge
  // and keeps the counter from ever passing cfg_period.
  always_comb begin
    state_next = state;
    rise_next  = '0;
    fall_next  = '0;
    for (int unsigned i = 0; i < AW; i++) begin
      cnt_next[i] = '0;
      if (cfg_bypass[i]) begin
        state_next[i] = sync2[i];
      end else if (sync2[i] != state[i]) begin
        if (cnt[i] < cfg_period) begin
          cnt_next[i] = CW'(cnt[i] + 1'b1);
        end else begin
          state_next[i] = sync2[i];
        end
      end
      rise_next[i] = state_next[i] & ~state[i];
      fall_next[i] = ~state_next[i] & state[i];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= '0;
      rise     <= '0;
      fall     <= '0;
      edge_any <= 1'b0;
      for (int unsigned i = 0; i < AW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      state    <= state_next;
      rise     <= rise_next;
      fall     <= fall_next;
      edge_any <= |(rise_next | fall_next);
      for (int unsigned i = 0; i < AW; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign gpio_in = state;

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed and random-noise checks for gpio_debounce with the default 32 pins.
module tb_gpio_debounce;

  logic        clk = 1'b0;
  logic        nreset;
  logic [31:0] pad_in;
  logic [7:0]  cfg_period;
  logic [31:0] cfg_bypass;
  logic [31:0] gpio_in;
  logic [31:0] rise;
  logic [31:0] fall;
  logic        edge_any;

  int checks   = 0;
  int failures = 0;

  gpio_debounce #(.AW(32), .CW(8)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .pad_in     (pad_in),
    .cfg_period (cfg_period),
    .cfg_bypass (cfg_bypass),
    .gpio_in    (gpio_in),
    .rise       (rise),
    .fall       (fall),
    .edge_any   (edge_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model state for the random phase
  logic [31:0] m_s1, m_s2, m_st, m_r, m_f;
  logic        m_e;
  logic [7:0]  m_cnt [32];

  task automatic model_edge();
    logic [31:0] n_st;
    logic [7:0]  n_cnt [32];
    n_st = m_st;
    for (int p = 0; p < 32; p++) begin
      n_cnt[p] = 8'd0;
      if (cfg_bypass[p]) n_st[p] = m_s2[p];
      else if (m_s2[p] !== m_st[p]) begin
        if (m_cnt[p] >= cfg_period) n_st[p] = m_s2[p];
        else n_cnt[p] = m_cnt[p] + 8'd1;
      end
    end
    m_r  = n_st & ~m_st;
    m_f  = m_st & ~n_st;
    m_e  = (m_r != 0) || (m_f != 0);
    m_st = n_st;
    for (int p = 0; p < 32; p++) m_cnt[p] = n_cnt[p];
    m_s2 = m_s1;
    m_s1 = pad_in;
  endtask

  initial begin
    logic [31:0] acc;
    nreset     = 1'b0;
    pad_in     = '0;
    cfg_period = 8'd3;
    cfg_bypass = '0;

    // Reset state
    step(2);
    chk("reset_outputs", {gpio_in, rise, fall, edge_any}, '0);
    nreset = 1'b1;
    step(3);
    chk("post_reset_idle", {gpio_in, rise, fall, edge_any}, '0);

    // P=3, pin 0 rises and holds
    pad_in = 32'h1;
    step(5);
    chk("p3_rise_early", {gpio_in, rise}, '0);
    step(1);
    chk("p3_rise_gpio", gpio_in, 32'h1);
    chk("p3_rise_pulse", {rise, fall, edge_any}, {32'h1, 32'h0, 1'b1});
    step(1);
    chk("p3_rise_one_cycle", {gpio_in, rise, fall, edge_any}, {32'h1, 64'h0, 1'b0});
    pad_in = 32'h0;
    step(6);
    chk("p3_fall", {gpio_in, rise, fall, edge_any}, {32'h0, 32'h0, 32'h1, 1'b1});
    step(1);

    // P=3, pin 5 glitch of 3 cycles is rejected
    pad_in = 32'h20;
    acc = '0;
    repeat (3) begin
      step(1);
      acc |= gpio_in | rise | fall;
    end
    pad_in = 32'h0;
    repeat (10) begin
      step(1);
      acc |= gpio_in | rise | fall;
    end
    chk("glitch_rejected", acc, 32'h0);

    // P=0, pin 1: three-cycle latency
    cfg_period = 8'd0;
    pad_in = 32'h2;
    step(2);
    chk("p0_rise_early", gpio_in, 32'h0);
    step(1);
    chk("p0_rise", {gpio_in, rise, fall, edge_any}, {32'h2, 32'h2, 32'h0, 1'b1});
    step(1);
    chk("p0_rise_clear", {rise, edge_any}, '0);
    pad_in = 32'h0;
    step(3);
    chk("p0_fall", {gpio_in, rise, fall, edge_any}, {32'h0, 32'h0, 32'h2, 1'b1});

    // Bypass pin 7 with P=200
    cfg_period = 8'd200;
    cfg_bypass = 32'h80;
    pad_in = 32'h80;
    step(2);
    chk("byp_rise_early", gpio_in, 32'h0);
    step(1);
    chk("byp_rise", {gpio_in, rise, fall, edge_any}, {32'h80, 32'h80, 32'h0, 1'b1});
    step(1);
    chk("byp_rise_clear", {rise, edge_any}, '0);
    pad_in = 32'h0;
    step(3);
    chk("byp_fall", {gpio_in, rise, fall, edge_any}, {32'h0, 32'h0, 32'h80, 1'b1});
    step(1);
    chk("byp_fall_clear", {fall, edge_any}, '0);
    cfg_bypass = '0;
    step(2);

    // P=10 all ones, period dropped to 2 mid-count
    cfg_period = 8'd10;
    pad_in = 32'hFFFF_FFFF;
    step(6);
    chk("drop_period_early", gpio_in, 32'h0);
    cfg_period = 8'd2;
    step(1);
    chk("drop_period_all", {gpio_in, rise, fall, edge_any},
        {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1});
    step(1);
    chk("drop_period_clear", {gpio_in, rise, edge_any}, {32'hFFFF_FFFF, 32'h0, 1'b0});
    cfg_period = 8'd0;
    pad_in = 32'h0;
    step(3);
    chk("all_fall", {gpio_in, fall}, {32'h0, 32'hFFFF_FFFF});

    // Reset mid-count; pins held high through reset rise after 11 cycles
    pad_in = 32'h1;
    step(3);
    chk("pre_reset_state", gpio_in, 32'h1);
    cfg_period = 8'd8;
    pad_in = 32'h9;
    step(7);
    chk("mid_count_hold", {gpio_in, rise}, {32'h1, 32'h0});
    nreset = 1'b0;
    #1;
    chk("async_reset_clear", {gpio_in, rise, fall, edge_any}, '0);
    step(2);
    nreset = 1'b1;
    acc = '0;
    repeat (10) begin
      step(1);
      acc |= gpio_in | rise | fall;
    end
    chk("post_release_quiet", acc, 32'h0);
    step(1);
    chk("post_release_rise", {gpio_in, rise, fall, edge_any}, {32'h9, 32'h9, 32'h0, 1'b1});

    // Random noise against the reference model
    nreset = 1'b0;
    pad_in = '0;
    cfg_period = 8'd3;
    cfg_bypass = 32'h00F0_0000;
    step(2);
    m_s1 = '0; m_s2 = '0; m_st = '0; m_r = '0; m_f = '0; m_e = 1'b0;
    for (int p = 0; p < 32; p++) m_cnt[p] = 8'd0;
    nreset = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("random_model", {gpio_in, rise, fall, edge_any}, {m_st, m_r, m_f, m_e});
      if (i == 10000) cfg_period = 8'd1;
      if (i == 15000) cfg_bypass = '0;
      pad_in = pad_in ^ ($urandom & $urandom & $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
